// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit.
//   - RV32I funct3 width/sign codes for loads and stores
//   - response error codes
//   - FSM state encoding
package lsu_pkg;

   // funct3 width/sign codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // response error codes
   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_OOR      = 2'b10;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the load/store unit (purely combinational).
//   i_funct3     : width/sign code of the access
//   i_addr_lo    : byte offset within the word (addr[1:0])
//   i_word       : 32-bit memory word (buffered read data)
//   i_wdata      : store data; low byte/half used for SB/SH
//   o_load_data  : selected lane, sign- or zero-extended
//   o_store_word : i_word with the addressed lane replaced (SW: i_wdata)
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load_data,
   output logic [31:0] o_store_word
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
      w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];

      o_load_data = 32'd0;
      case (i_funct3)
         F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
         F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
         F3_W:    o_load_data = i_word;
         F3_BU:   o_load_data = {24'd0, w_byte};
         F3_HU:   o_load_data = {16'd0, w_half};
         default: o_load_data = 32'd0;
      endcase

      // Read-modify-write merge: untouched lanes keep the word just read.
      o_store_word = i_word;
      case (i_funct3)
         F3_B:    o_store_word[{i_addr_lo, 3'b000} +: 8]     = i_wdata[7:0];
         F3_H:    o_store_word[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
         F3_W:    o_store_word = i_wdata;
         default: o_store_word = i_word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-addressed data memory.
// Converts byte-addressed RV32I loads/stores into word accesses, builds
// SB/SH by read-modify-write, and checks errors before touching memory.
//   clk, rst        : clock, synchronous active-high reset
//   req_*           : request (valid/ready), store flag, funct3, addr, data
//   resp_valid      : one-cycle completion pulse with resp_rdata/resp_err
//   mem_ena         : memory write strobe (never high while rst is high)
//   mem_addr        : word index {2'b00, addr[31:2]}
//   mem_wdata       : full word to write
//   mem_rdata       : memory read data for mem_addr, same cycle
//   dbg_state       : current FSM state
//
// Handshake: a request is taken on a rising edge where req_valid and
// req_ready are both high; all req_* fields are latched on that edge.
// req_ready is high only in IDLE (and low during reset). resp_valid is a
// single-cycle pulse with no back-pressure.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = 1024
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_err,
   output logic        mem_ena,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  dbg_state
);

   localparam logic [29:0] LP_LIMIT = 30'(MEM_WORDS);

   logic [1:0]  r_state;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [1:0]  r_err;
   logic [31:0] r_buf;

   logic        w_legal;
   logic        w_misalign;
   logic        w_oor;
   logic [1:0]  w_err;
   logic [31:0] w_load_data;
   logic [31:0] w_store_word;

   // Error classification of the incoming request, highest priority first.
   always_comb begin
      w_legal = 1'b0;
      case (req_funct3)
         F3_B, F3_H, F3_W: w_legal = 1'b1;
         F3_BU, F3_HU:     w_legal = !req_we;
         default:          w_legal = 1'b0;
      endcase
      // funct3[1:0]==01 covers both LH/SH and LHU
      w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
      w_oor      = req_addr[31:2] >= LP_LIMIT;
      if (!w_legal)        w_err = ERR_ILLEGAL;
      else if (w_misalign) w_err = ERR_MISALIGN;
      else if (w_oor)      w_err = ERR_OOR;
      else                 w_err = ERR_OK;
   end

   lsu_align u_align (
      .i_funct3     (r_funct3),
      .i_addr_lo    (r_addr[1:0]),
      .i_word       (r_buf),
      .i_wdata      (r_wdata),
      .o_load_data  (w_load_data),
      .o_store_word (w_store_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_we     <= 1'b0;
         r_funct3 <= 3'd0;
         r_addr   <= 32'd0;
         r_wdata  <= 32'd0;
         r_err    <= ERR_OK;
         r_buf    <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_we     <= req_we;
                  r_funct3 <= req_funct3;
                  r_addr   <= req_addr;
                  r_wdata  <= req_wdata;
                  r_err    <= w_err;
                  if (w_err != ERR_OK)
                     r_state <= ST_RESP;
                  else if (req_we && (req_funct3 == F3_W))
                     r_state <= ST_WRITE;
                  else
                     r_state <= ST_READ;
               end
            end
            ST_READ: begin
               r_buf   <= mem_rdata;
               r_state <= r_we ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: r_state <= ST_RESP;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   // Outputs are gated by rst so nothing leaks out of a stale state
   // during the reset cycle itself.
   always_comb begin
      req_ready  = (r_state == ST_IDLE) && !rst;
      resp_valid = (r_state == ST_RESP) && !rst;
      resp_err   = resp_valid ? r_err : ERR_OK;
      resp_rdata = (resp_valid && !r_we && (r_err == ERR_OK)) ? w_load_data : 32'd0;
      mem_ena    = (r_state == ST_WRITE) && !rst;
      mem_addr   = {2'b00, r_addr[31:2]};
      mem_wdata  = (r_state == ST_WRITE) ? w_store_word : 32'd0;
      dbg_state  = r_state;
   end

endmodule
